frame_sequencer: RTL and testbench

//  Byte-level sequencer for the Ethernet packet detector. Tracks each received byte through

---
 rtl/eth_pkg.sv | 54 +++++
 rtl/sat_counter.sv | 29 ++
 rtl/frame_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_frame_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared encodings for the Ethernet frame sequencer: FSM states, field/error codes,
// header field lengths and frame-size constants.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DST  = 3'd2,
        ST_SRC  = 3'd3,
        ST_TL   = 3'd4,
        ST_PAY  = 3'd5,
        ST_DROP = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    localparam logic [2:0] FLD_IDLE = 3'd0;
    localparam logic [2:0] FLD_PRE  = 3'd1;
    localparam logic [2:0] FLD_DST  = 3'd2;
    localparam logic [2:0] FLD_SRC  = 3'd3;
    localparam logic [2:0] FLD_TL   = 3'd4;
    localparam logic [2:0] FLD_PAY  = 3'd5;
    localparam logic [2:0] FLD_NONE = 3'd7;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_HDR   = 3'd1;
    localparam logic [2:0] ERR_RUNT  = 3'd2;
    localparam logic [2:0] ERR_GIANT = 3'd3;
    localparam logic [2:0] ERR_LEN   = 3'd4;
    localparam logic [2:0] ERR_CRC   = 3'd5;
    localparam logic [2:0] ERR_TRUNC = 3'd6;

    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] PRE_LEN = 4'd8;
    localparam logic [IDX_W-1:0] DST_LEN = 4'd6;
    localparam logic [IDX_W-1:0] SRC_LEN = 4'd6;
    localparam logic [IDX_W-1:0] TL_LEN  = 4'd2;

    localparam int MIN_PAYLOAD   = 46;
    localparam int MAX_LEN_FIELD = 1500;
    localparam int HDR_FCS_OVH   = 18;

    function automatic logic [2:0] field_of(input state_t s);
        case (s)
            ST_IDLE: field_of = FLD_IDLE;
            ST_PRE:  field_of = FLD_PRE;
            ST_DST:  field_of = FLD_DST;
            ST_SRC:  field_of = FLD_SRC;
            ST_TL:   field_of = FLD_TL;
            ST_PAY:  field_of = FLD_PAY;
            default: field_of = FLD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. clr restarts the count; clr together with inc loads 1 so the
// event that restarts a count is itself counted.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] base;

    always_comb base = clr ? '0 : count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (base != MAX)) begin
            count <= base + WIDTH'(1);
        end else begin
            count <= base;
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Byte-level Ethernet frame sequencer: walks PRE/DST/SRC/TL/PAY, gates on checker verdicts,
// enforces size limits and reports one verdict per frame. FRAME_SEQ_STATS_EN adds good/bad counters.
module frame_sequencer
    import eth_pkg::*;
#(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int CNT_W     = 11
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        control,
    input  logic        data_valid,
    input  logic        preamble_valid,
    input  logic        dst_addr_valid,
    input  logic        src_addr_valid,
    input  logic        type_length_valid,
    input  logic [15:0] type_length,
    input  logic        crc_ok,
    output logic        enable_header,
    output logic        enable_payload,
    output logic [2:0]  field,
    output logic        frame_done,
    output logic        frame_good,
    output logic [2:0]  err_code,
    output logic [2:0]  state_dbg
`ifdef FRAME_SEQ_STATS_EN
    ,
    output logic [31:0] good_cnt,
    output logic [31:0] bad_cnt
`endif
);

    localparam int PW = CNT_W + 1;

    // A byte is transferred on a rising edge only when control and data_valid are both high;
    // data_valid low with control high is a stall that holds state and counters.
    state_t             state, state_nx;
    logic [IDX_W-1:0]   idx, fld_last;
    logic [CNT_W-1:0]   fcnt, exp_pay_q, exp_pay_nx;
    logic [2:0]         err_q, err_nx, verdict;
    logic               byte_in, fld_ok, tl_ld, len_mode_q, len_mode_nx;
    logic               idx_clr, idx_inc, fcnt_clr, fcnt_inc;
    state_t             fld_next;

    assign byte_in  = control & data_valid;
    assign fcnt_clr = (state == ST_IDLE);
    assign fcnt_inc = byte_in && (state inside {ST_DST, ST_SRC, ST_TL, ST_PAY});

    sat_counter #(.WIDTH(IDX_W)) u_idx (
        .clock(clock), .reset_n(reset_n), .clr(idx_clr), .inc(idx_inc), .count(idx)
    );

    sat_counter #(.WIDTH(CNT_W)) u_fcnt (
        .clock(clock), .reset_n(reset_n), .clr(fcnt_clr), .inc(fcnt_inc), .count(fcnt)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        fld_last = '0;
        fld_ok   = 1'b0;
        fld_next = ST_IDLE;
        case (state)
            ST_PRE: begin fld_last = PRE_LEN - 4'd1; fld_ok = preamble_valid;    fld_next = ST_DST; end
            ST_DST: begin fld_last = DST_LEN - 4'd1; fld_ok = dst_addr_valid;    fld_next = ST_SRC; end
            ST_SRC: begin fld_last = SRC_LEN - 4'd1; fld_ok = src_addr_valid;    fld_next = ST_TL;  end
            ST_TL:  begin fld_last = TL_LEN - 4'd1;  fld_ok = type_length_valid; fld_next = ST_PAY; end
            default: ;
        endcase
    end

    // Size checks come first; the length check cannot underflow because fcnt >= MIN_FRAME there.
    always_comb begin
        if (fcnt < CNT_W'(MIN_FRAME)) begin
            verdict = ERR_RUNT;
        end else if (fcnt > CNT_W'(MAX_FRAME)) begin
            verdict = ERR_GIANT;
        end else if (len_mode_q && (PW'(fcnt) < PW'(exp_pay_q) + PW'(HDR_FCS_OVH))) begin
            verdict = ERR_LEN;
        end else if (!crc_ok) begin
            verdict = ERR_CRC;
        end else begin
            verdict = ERR_NONE;
        end
    end

    always_comb begin
        state_nx = state;
        err_nx   = err_q;
        tl_ld    = 1'b0;
        idx_clr  = 1'b0;
        idx_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                idx_clr = 1'b1;
                if (byte_in) begin
                    idx_inc  = 1'b1;
                    state_nx = ST_PRE;
                    err_nx   = ERR_NONE;
                end
            end
            ST_PRE, ST_DST, ST_SRC, ST_TL: begin
                if (!control) begin
                    state_nx = ST_DONE;
                    err_nx   = ERR_TRUNC;
                end else if (data_valid) begin
                    if (idx == fld_last) begin
                        idx_clr = 1'b1;
                        if (fld_ok) begin
                            state_nx = fld_next;
                            tl_ld    = (state == ST_TL);
                        end else begin
                            state_nx = ST_DROP;
                            err_nx   = ERR_HDR;
                        end
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            ST_PAY: begin
                if (!control) begin
                    state_nx = ST_DONE;
                    err_nx   = verdict;
                end
            end
            ST_DROP: begin
                if (!control) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign len_mode_nx = (type_length <= 16'(MAX_LEN_FIELD));
    assign exp_pay_nx  = (type_length < 16'(MIN_PAYLOAD)) ? CNT_W'(MIN_PAYLOAD) : CNT_W'(type_length);

    // Enables follow the state one cycle late; err_q holds the verdict through DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enable_header  <= 1'b1;
            enable_payload <= 1'b0;
            err_q          <= ERR_NONE;
            len_mode_q     <= 1'b0;
            exp_pay_q      <= '0;
        end else begin
            enable_header  <= state inside {ST_IDLE, ST_PRE, ST_DST, ST_SRC, ST_TL};
            enable_payload <= (state == ST_PAY);
            err_q          <= err_nx;
            if (tl_ld) begin
                len_mode_q <= len_mode_nx;
                exp_pay_q  <= len_mode_nx ? exp_pay_nx : '0;
            end
        end
    end

    always_comb begin
        frame_done = (state == ST_DONE);
        frame_good = (state == ST_DONE) && (err_q == ERR_NONE);
        err_code   = (state == ST_DONE) ? err_q : ERR_NONE;
        field      = field_of(state);
        state_dbg  = state;
    end

`ifdef FRAME_SEQ_STATS_EN
    sat_counter #(.WIDTH(32)) u_good_cnt (
        .clock(clock), .reset_n(reset_n), .clr(1'b0), .inc(frame_done & frame_good), .count(good_cnt)
    );

    sat_counter #(.WIDTH(32)) u_bad_cnt (
        .clock(clock), .reset_n(reset_n), .clr(1'b0), .inc(frame_done & ~frame_good), .count(bad_cnt)
    );
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: hand-computed verdicts per frame, enable/field checks,
// truncation, mid-frame reset and (with FRAME_SEQ_STATS_EN) the good/bad counters.
module tb_frame_sequencer;
    import eth_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        control;
    logic        data_valid;
    logic        preamble_valid;
    logic        dst_addr_valid;
    logic        src_addr_valid;
    logic        type_length_valid;
    logic [15:0] type_length;
    logic        crc_ok;
    logic        enable_header;
    logic        enable_payload;
    logic [2:0]  field;
    logic        frame_done;
    logic        frame_good;
    logic [2:0]  err_code;
    logic [2:0]  state_dbg;
`ifdef FRAME_SEQ_STATS_EN
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;
`endif

    frame_sequencer dut (
        .clock(clock),
        .reset_n(reset_n),
        .control(control),
        .data_valid(data_valid),
        .preamble_valid(preamble_valid),
        .dst_addr_valid(dst_addr_valid),
        .src_addr_valid(src_addr_valid),
        .type_length_valid(type_length_valid),
        .type_length(type_length),
        .crc_ok(crc_ok),
        .enable_header(enable_header),
        .enable_payload(enable_payload),
        .field(field),
        .frame_done(frame_done),
        .frame_good(frame_good),
        .err_code(err_code),
        .state_dbg(state_dbg)
`ifdef FRAME_SEQ_STATS_EN
        ,
        .good_cnt(good_cnt),
        .bad_cnt(bad_cnt)
`endif
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_good_n = 0;
    int         exp_bad_n = 0;
    logic [3:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame of 8 preamble bytes plus n bytes DST..FCS. bad_byte marks the byte whose field
    // valid is low, stop_at drops control before that byte, gap_every inserts stall cycles.
    task automatic run_frame(input string tag, input int n, input logic [15:0] tl, input logic crc,
                             input int bad_byte, input int stop_at, input int gap_every,
                             input logic exp_good, input logic [2:0] exp_err,
                             input logic done_byte, input int gap_after);
        int         total;
        logic [3:0] e;
        total = 8 + n;
        exp_q.push_back({exp_good, exp_err});
        type_length = tl;
        crc_ok      = crc;
        for (int b = 0; b < total; b++) begin
            if (b == stop_at) break;
            if (gap_every > 0 && b > 0 && (b % gap_every) == 0) begin
                control = 1'b1; data_valid = 1'b0;
                preamble_valid = 1'b1; dst_addr_valid = 1'b1;
                src_addr_valid = 1'b1; type_length_valid = 1'b1;
                @(negedge clock);
            end
            if (bad_byte >= 0 && b == bad_byte + 2) begin
                check_eq({tag, "_drop_en_hdr"}, 32'(enable_header), 32'd0);
                check_eq({tag, "_drop_en_pay"}, 32'(enable_payload), 32'd0);
            end
            if (b == 25 && bad_byte < 0 && stop_at < 0) begin
                check_eq({tag, "_pay_en_pay"}, 32'(enable_payload), 32'd1);
                check_eq({tag, "_pay_en_hdr"}, 32'(enable_header), 32'd0);
                check_eq({tag, "_pay_field"}, 32'(field), 32'(FLD_PAY));
            end
            preamble_valid    = !(b == bad_byte && b < 8);
            dst_addr_valid    = !(b == bad_byte && b >= 8 && b < 14);
            src_addr_valid    = !(b == bad_byte && b >= 14 && b < 20);
            type_length_valid = !(b == bad_byte && b >= 20 && b < 22);
            control = 1'b1; data_valid = 1'b1;
            @(negedge clock);
        end
        control = 1'b0; data_valid = 1'b0;
        preamble_valid = 1'b1; dst_addr_valid = 1'b1;
        src_addr_valid = 1'b1; type_length_valid = 1'b1;
        @(negedge clock);
        check_eq({tag, "_done"}, 32'(frame_done), 32'd1);
        e = exp_q.pop_front();
        check_eq({tag, "_verdict"}, 32'({frame_good, err_code}), 32'(e));
        if (e[3]) exp_good_n++; else exp_bad_n++;
        if (done_byte) begin
            control = 1'b1; data_valid = 1'b1;
        end
        @(negedge clock);
        check_eq({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
        control = 1'b0; data_valid = 1'b0;
        repeat (gap_after) @(negedge clock);
    endtask

    initial begin
        logic seen;
        reset_n = 1'b0; control = 1'b0; data_valid = 1'b0;
        preamble_valid = 1'b1; dst_addr_valid = 1'b1;
        src_addr_valid = 1'b1; type_length_valid = 1'b1;
        type_length = 16'h0000; crc_ok = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("rst_en_hdr", 32'(enable_header), 32'd1);
        check_eq("rst_en_pay", 32'(enable_payload), 32'd0);
        check_eq("rst_done", 32'(frame_done), 32'd0);
        check_eq("rst_err", 32'(err_code), 32'd0);
        check_eq("rst_field", 32'(field), 32'(FLD_IDLE));
        reset_n = 1'b1;
        @(negedge clock);

        run_frame("good64",     64,   16'h0800, 1'b1, -1, -1, 0, 1'b1, ERR_NONE,  1'b0, 2);
        run_frame("hdr_drop",   64,   16'h0800, 1'b1, 13, -1, 0, 1'b0, ERR_HDR,   1'b0, 1);
        run_frame("runt60",     60,   16'h0800, 1'b1, -1, -1, 0, 1'b0, ERR_RUNT,  1'b0, 0);
        run_frame("runt63",     63,   16'h0800, 1'b1, -1, -1, 0, 1'b0, ERR_RUNT,  1'b1, 0);
        run_frame("runt_after", 63,   16'h0800, 1'b1, -1, -1, 0, 1'b0, ERR_RUNT,  1'b0, 0);
        run_frame("max1518",    1518, 16'h0800, 1'b1, -1, -1, 0, 1'b1, ERR_NONE,  1'b0, 1);
        run_frame("giant1519",  1519, 16'h0800, 1'b1, -1, -1, 0, 1'b0, ERR_GIANT, 1'b0, 1);
        run_frame("giant3000",  3000, 16'h0800, 1'b1, -1, -1, 0, 1'b0, ERR_GIANT, 1'b0, 1);
        run_frame("len_short",  98,   16'd100,  1'b1, -1, -1, 5, 1'b0, ERR_LEN,   1'b0, 3);
        run_frame("crc_bad",    118,  16'd100,  1'b0, -1, -1, 7, 1'b0, ERR_CRC,   1'b0, 0);
        run_frame("len_ok",     118,  16'd100,  1'b1, -1, -1, 0, 1'b1, ERR_NONE,  1'b0, 0);
        run_frame("len_pad46",  64,   16'd20,   1'b1, -1, -1, 0, 1'b1, ERR_NONE,  1'b0, 0);
        run_frame("len_gt1500", 64,   16'd1501, 1'b1, -1, -1, 0, 1'b1, ERR_NONE,  1'b0, 0);
        run_frame("tl_drop",    64,   16'h0800, 1'b1, 21, -1, 0, 1'b0, ERR_HDR,   1'b0, 0);
        run_frame("trunc_src",  64,   16'h0800, 1'b1, -1, 17, 0, 1'b0, ERR_TRUNC, 1'b0, 2);

        // reset in the middle of the payload: no verdict for the aborted frame
        type_length = 16'h0800; crc_ok = 1'b1;
        for (int b = 0; b < 40; b++) begin
            control = 1'b1; data_valid = 1'b1;
            @(negedge clock);
        end
        check_eq("pre_rst_en_pay", 32'(enable_payload), 32'd1);
        reset_n = 1'b0;
        #1;
        exp_good_n = 0; exp_bad_n = 0;
        check_eq("midrst_en_hdr", 32'(enable_header), 32'd1);
        check_eq("midrst_en_pay", 32'(enable_payload), 32'd0);
        check_eq("midrst_field", 32'(field), 32'(FLD_IDLE));
        check_eq("midrst_done", 32'(frame_done), 32'd0);
        control = 1'b0; data_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (frame_done) seen = 1'b1;
        end
        check_eq("midrst_no_done", 32'(seen), 32'd0);

        run_frame("st_good_a", 64, 16'h0800, 1'b1, -1, -1, 0, 1'b1, ERR_NONE, 1'b0, 0);
        run_frame("st_good_b", 80, 16'h0800, 1'b1, -1, -1, 0, 1'b1, ERR_NONE, 1'b0, 5);
        run_frame("st_bad_c",  64, 16'h0800, 1'b0, -1, -1, 0, 1'b0, ERR_CRC,  1'b0, 0);
        run_frame("st_good_d", 64, 16'h0800, 1'b1, -1, -1, 0, 1'b1, ERR_NONE, 1'b0, 5);
        run_frame("st_bad_e",  50, 16'h0800, 1'b1, -1, -1, 0, 1'b0, ERR_RUNT, 1'b0, 2);
`ifdef FRAME_SEQ_STATS_EN
        check_eq("good_cnt", good_cnt, 32'(exp_good_n));
        check_eq("bad_cnt", bad_cnt, 32'(exp_bad_n));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
